// File: rtl/dot_pipeline_pkg.sv
// Shared constants and helpers for the dot-product pipeline.
// Optional macro DOT_PIPELINE_SIGNED_EN selects two's-complement operands.
package dot_pipeline_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 2;
  localparam int DEF_ACC_W =
    2 * DEF_WIDTH + clog2(DEF_LANES) + 8;

  // Partial-sum width at tree level lvl for product width pw.
  function automatic int lvl_w(input int pw, input int lvl);
    return pw + lvl;
  endfunction

`ifdef DOT_PIPELINE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

endpackage

// File: rtl/dot_pipeline_adder_tree.sv
// Registered binary adder tree; one register level per pairing step.
// Ports: clk, rst_n, en, clear, in_valid/in_last, lanes in; out_valid/out_last, sum out.
module dot_pipeline_adder_tree
  import dot_pipeline_pkg::*;
#(
  parameter int IW = 16,
  parameter int LANES = 2,
  localparam int D = clog2(LANES),
  localparam int OW = lvl_w(IW, D)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [LANES*IW-1:0] lanes,
  output logic                out_valid,
  output logic                out_last,
  output logic [OW-1:0]       sum
);

  for (genvar l = 0; l <= D; l++) begin : lv
    localparam int N = LANES >> l;
    localparam int LW = lvl_w(IW, l);
    logic [N*LW-1:0] s;
    logic            v;
    logic            t;

    if (l == 0) begin : g_in
      assign s = lanes;
      assign v = in_valid;
      assign t = in_last;
    end else begin : g_add
      logic [N*LW-1:0] d;
      for (genvar j = 0; j < N; j++) begin : pr
        logic [LW-2:0] x;
        logic [LW-2:0] y;
        assign x = lv[l-1].s[(2*j)*(LW-1) +: LW-1];
        assign y = lv[l-1].s[(2*j+1)*(LW-1) +: LW-1];
        assign d[j*LW +: LW] =
          {SIGNED_EN & x[LW-2], x} +
          {SIGNED_EN & y[LW-2], y};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s <= '0;
          v <= 1'b0;
          t <= 1'b0;
        end else if (clear) begin
          v <= 1'b0;
          t <= 1'b0;
        end else if (en) begin
          s <= d;
          v <= lv[l-1].v;
          t <= lv[l-1].t;
        end
      end
    end
  end

  assign sum       = lv[D].s;
  assign out_valid = lv[D].v;
  assign out_last  = lv[D].t;

endmodule

// File: rtl/dot_pipeline.sv
// LANES-wide multiply/adder-tree/accumulate pipeline with valid/ready and flush.
// Ports: clk, rst_n, flush, in_* beat (valid/ready/a/b/last), out_* result (valid/ready/data).
// DOT_PIPELINE_SIGNED_EN selects signed operands.
module dot_pipeline
  import dot_pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int ACC_W = 2 * WIDTH + clog2(LANES) + 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data
);

  localparam int PW = 2 * WIDTH;
  localparam int D  = clog2(LANES);
  localparam int TW = lvl_w(PW, D);

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic [LANES*PW-1:0] prod;
  logic [LANES*PW-1:0] p_q;
  logic                v1;
  logic                l1;

  for (genvar i = 0; i < LANES; i++) begin : mul
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [PW-1:0]    ax;
    logic [PW-1:0]    bx;
    assign a  = in_a[i*WIDTH +: WIDTH];
    assign b  = in_b[i*WIDTH +: WIDTH];
    // Low PW bits of the extended product are exact in both builds.
    assign ax = {{WIDTH{SIGNED_EN & a[WIDTH-1]}}, a};
    assign bx = {{WIDTH{SIGNED_EN & b[WIDTH-1]}}, b};
    assign prod[i*PW +: PW] = ax * bx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      v1  <= 1'b0;
      l1  <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else if (!stall) begin
      p_q <= prod;
      v1  <= in_valid;
      l1  <= in_last;
    end
  end

  logic          t_valid;
  logic          t_last;
  logic [TW-1:0] t_sum;

  dot_pipeline_adder_tree #(
    .IW    (PW),
    .LANES (LANES)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (!stall),
    .clear     (flush),
    .in_valid  (v1),
    .in_last   (l1),
    .lanes     (p_q),
    .out_valid (t_valid),
    .out_last  (t_last),
    .sum       (t_sum)
  );

  logic [ACC_W-1:0] t_ext;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;

  if (ACC_W > TW) begin : g_ext
    assign t_ext = {{(ACC_W-TW){SIGNED_EN & t_sum[TW-1]}}, t_sum};
  end else if (ACC_W == TW) begin : g_eq
    assign t_ext = t_sum;
  end else begin : g_trunc
    assign t_ext = t_sum[ACC_W-1:0];
  end

  assign sum = acc_q + t_ext;

  // When not stalled, any held result is being consumed this cycle,
  // so out_valid reflects only whether a new result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= t_valid && t_last;
      if (t_valid) begin
        if (t_last) begin
          out_data <= sum;
          acc_q    <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_pipeline.sv
// Scoreboard bench for dot_pipeline (LANES=2 default and LANES=4/ACC_W=16).
// Honours DOT_PIPELINE_SIGNED_EN in its reference model.
module tb_dot_pipeline;

  localparam int AW  = 25;
  localparam int AW4 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush, in_valid, in_ready, in_last;
  logic          out_valid, out_ready;
  logic [15:0]   in_a, in_b;
  logic [AW-1:0] out_data;

  logic           flush4, in_valid4, in_ready4, in_last4;
  logic           out_valid4, out_ready4;
  logic [31:0]    in_a4, in_b4;
  logic [AW4-1:0] out_data4;

  dot_pipeline u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  dot_pipeline #(
    .WIDTH (8),
    .LANES (4),
    .ACC_W (AW4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_a      (in_a4),
    .in_b      (in_b4),
    .in_last   (in_last4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] q2[$];
  logic [63:0] q4[$];
  longint acc2 = 0;
  longint acc4 = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint dotm(input logic [63:0] a,
                                  input logic [63:0] b, input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] x8, y8;
      longint x, y;
      x8 = a[i*8 +: 8];
      y8 = b[i*8 +: 8];
`ifdef DOT_PIPELINE_SIGNED_EN
      x = longint'($signed(x8));
      y = longint'($signed(y8));
`else
      x = longint'(x8);
      y = longint'(y8);
`endif
      s += x * y;
    end
    return s;
  endfunction

  function automatic logic [63:0] wrap(input longint v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return v & m;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q2.size() == 0) check("unexpected_out", q2.size(), 1);
      else check("out_data", out_data, q2.pop_front());
    end
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4.size() == 0) check("unexpected_out4", q4.size(), 1);
      else check("out_data4", out_data4, q4.pop_front());
    end
  end

  // Called and returns at posedge+1; beat accepted at a posedge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic last);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", {63'd0, in_ready}, 1);
      in_valid = 1'b0;
      return;
    end
    acc2 += dotm(a, b, 2);
    if (last) begin
      q2.push_back(wrap(acc2, AW));
      acc2 = 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send4(input logic [31:0] a, input logic [31:0] b,
                       input logic last);
    int n = 0;
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_last4 = last;
    @(negedge clk);
    while (!in_ready4 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready4) begin
      check("accept_timeout4", {63'd0, in_ready4}, 1);
      in_valid4 = 1'b0;
      return;
    end
    acc4 += dotm(a, b, 4);
    if (last) begin
      q4.push_back(wrap(acc4, AW4));
      acc4 = 0;
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_last4 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    while ((q2.size() != 0 || q4.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q2.size() + q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    flush = 0; in_valid = 0; in_a = 0; in_b = 0; in_last = 0;
    out_ready = 1;
    flush4 = 0; in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_last4 = 0;
    out_ready4 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid4", out_valid4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single beat: 3*5 + 4*6 = 39, visible 3 cycles after acceptance
    send({8'd4, 8'd3}, {8'd6, 8'd5}, 1'b1);
    @(negedge clk); check("lat_c1", out_valid, 0);
    @(negedge clk); check("lat_c2", out_valid, 0);
    @(negedge clk); check("lat_c3", out_valid, 1);
    drain();

    // burst of three 11s, then a single 5
    send({8'd2, 8'd1}, {8'd4, 8'd3}, 1'b0);
    send({8'd2, 8'd1}, {8'd4, 8'd3}, 1'b0);
    send({8'd2, 8'd1}, {8'd4, 8'd3}, 1'b1);
    send({8'd2, 8'd1}, {8'd2, 8'd1}, 1'b1);
    drain();

    // backpressure over six results 1..6
    fork
      begin
        for (int k = 1; k <= 6; k++)
          send({8'd0, 8'(k)}, {8'd0, 8'd1}, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // a=(-2,3), b=(4,5): 7 signed, 1031 unsigned
    send({8'd3, 8'hFE}, {8'd5, 8'd4}, 1'b1);
    drain();

    // flush after beat 2; beat 3 presented during flush is dropped
    send({8'd2, 8'd1}, {8'd4, 8'd3}, 1'b0);
    send({8'd2, 8'd1}, {8'd4, 8'd3}, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    acc2 = 0;
    repeat (5) begin
      @(negedge clk);
      check("flush_no_out", out_valid, 0);
    end
    @(posedge clk); #1;
    send({8'd4, 8'd3}, {8'd6, 8'd5}, 1'b1);
    drain();

    // LANES=4: 1+2+3+4 = 10, visible 4 cycles after acceptance
    send4({8'd4, 8'd3, 8'd2, 8'd1}, 32'h01010101, 1'b1);
    @(negedge clk); check("lat4_c1", out_valid4, 0);
    @(negedge clk); check("lat4_c2", out_valid4, 0);
    @(negedge clk); check("lat4_c3", out_valid4, 0);
    @(negedge clk); check("lat4_c4", out_valid4, 1);
    drain();
    // ACC_W=16 wrap: two beats of 255*255*4
    send4(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send4(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    drain();

    // async reset mid-stream clears outputs at once
    send({8'd4, 8'd3}, {8'd6, 8'd5}, 1'b1);
    send({8'd2, 8'd1}, {8'd2, 8'd1}, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_in_ready", in_ready, 1);
    q2.delete();
    acc2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send({8'd4, 8'd3}, {8'd6, 8'd5}, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
